spw_tx_encoder: RTL and testbench
=================================

Name: spw_tx_encoder

Overview:
SpaceWire transmitter serialiser; consumes the one-cycle bit-rate enable from the TX clock divider and drives the Data/Strobe (D/S) line pair. It selects and sends characters by priority: time-code, FCT, N-char (data/EOP/EEP), then NULL. It builds parity, control flag and strobe per bit. The link-state FSM gates it through TX_EN/SEND_FCT_EN/SEND_DATA_EN; the host side feeds N-chars over a valid/ready handshake.

Parameters:
EOP_CODE, 8'h00, low byte that marks EOP when TX_DATA[8]=1
EEP_CODE, 8'h01, low byte that marks EEP when TX_DATA[8]=1; any other control byte is also sent as EEP

Ports:
CLOCK  in  1  system clock
RESETn  in  1  asynchronous active-low reset
CLK_EN  in  1  one-cycle bit enable from TX clock divider; one bit is emitted per pulse
TX_EN  in  1  transmitter enable; 0 forces D=S=0
SEND_FCT_EN  in  1  FCTs may be sent
SEND_DATA_EN  in  1  N-chars and time-codes may be sent (Run)
TX_WRITE  in  1  N-char valid
TX_DATA  in  9  [8]=control flag, [7:0]=data or EOP/EEP code
TX_READY  out  1  single-entry holding register empty
FCT_REQ  in  1  level request; hold until FCT_ACK
FCT_ACK  out  1  one-cycle pulse when the FCT starts transmission
TICK_IN  in  1  one-cycle time-code request
TIME_IN  in  8  time-code value, sampled with TICK_IN
DOUT  out  1  SpaceWire Data
SOUT  out  1  SpaceWire Strobe

Behaviour:
- Reset: DOUT=0, SOUT=0, TX_READY=0, FCT_ACK=0. Holding register, pending tick and parity accumulator are cleared.
- Transmitted bit order per character: P, flag, then payload. FCT=P,1,0,0. EOP=P,1,0,1. EEP=P,1,1,0. ESC=P,1,1,1. Data=P,0,d0..d7 (LSB first).
- NULL is the character ESC followed by FCT. A time-code is ESC followed by a data character carrying TIME_IN. Both pairs are atomic; no other character may be inserted between them.
- Parity: P = 1 ^ acc ^ flag (odd). acc is the XOR of the payload bits of the previous character. acc=0 for the first character after TX_EN rises.
- Strobe: on each emitted bit, if the new D equals the previous D, S toggles; otherwise S holds. D^S therefore alternates every bit.
- DOUT/SOUT are registered. They update on the clock edge at which CLK_EN=1 is sampled. Between pulses they hold.
- Character selection happens at the CLK_EN on which the last bit of the current character has been sent, or at the first CLK_EN after TX_EN rises. The first bit of the selected character goes out on that same edge, so there are no idle bits between characters.
- Selection priority:
  1. Pending tick, only if SEND_DATA_EN.
  2. FCT_REQ, only if SEND_FCT_EN or SEND_DATA_EN.
  3. Holding register full, only if SEND_DATA_EN.
  4. Otherwise NULL.
- FCT_ACK pulses for one cycle on the edge where the FCT is selected.
- Handshake: TX_READY=1 when TX_EN=1 and the holding register is empty. A character is accepted when TX_WRITE & TX_READY. The register is freed on the edge its character is selected. A new write is accepted no earlier than the following cycle.
- TICK_IN: latches TIME_IN and sets pending. A new TICK_IN while still pending overwrites the value. If TICK_IN arrives on the same edge that pending is consumed, the new tick stays pending.
- TX_EN=0, including mid-character: on the next edge D=S=0 and the bit counter, holding register, pending tick and acc are cleared. FCT_ACK=0 and TX_READY=0. Restart always begins with a NULL.
- SEND_DATA_EN falling mid-character: the current character (or atomic pair) completes, and later selections obey the new gating.
- CLK_EN while TX_EN=0 is ignored.

Optional Feature:
SPWTCR_TX_CHAR_COUNT_EN
- Defined: adds output TX_NCHAR_CNT[15:0]. It increments once per N-char (data/EOP/EEP) at selection and wraps 16'hFFFF to 0. It clears on reset and whenever TX_EN=0. Time-codes and NULL/FCT do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, TX_EN=1, CLK_EN every cycle, other enables 0 -> D stream 0,1,1,1,0,1,0,0 repeated. S over the first 8 bits is 1,1,0,1,1,1,1,0. D^S alternates throughout. TX_READY=1, with no data sent.
- SEND_DATA_EN=1, write 9'h055 during a NULL -> after the NULL completes, D=1,0,1,0,1,0,1,0,1,0. Then write 9'h100 (EOP) -> D=0,1,0,1. TX_READY is low from accept until selection.
- FCT_REQ=1 with SEND_FCT_EN=1 and data pending -> FCT (P,1,0,0) precedes data. FCT_ACK is a single pulse at selection. A NULL is never split.
- TICK_IN with TIME_IN=8'h3C while holding data and FCT_REQ are pending, in Run -> ESC then data char 8'h3C first, then FCT, then data. A second TICK_IN with 8'h07 before selection -> 8'h07 is sent.
- TX_EN dropped at bit 5 of a data character -> next edge D=S=0 and TX_READY=0. Re-enable -> the first character is ESC with P=0 (acc reset).
- CLK_EN period 20 cycles -> D/S change only on edges where CLK_EN=1, and all outputs hold between pulses.

Source files
------------

// File: rtl/spw_tx_encoder_if.sv
// Host-side port bundle of the SpaceWire transmitter: N-char handshake,
// FCT request/acknowledge and time-code tick.
interface spw_tx_encoder_if;
  logic       TX_WRITE;
  logic [8:0] TX_DATA;
  logic       TX_READY;
  logic       FCT_REQ;
  logic       FCT_ACK;
  logic       TICK_IN;
  logic [7:0] TIME_IN;

  modport master (
    output TX_WRITE,
    output TX_DATA,
    output FCT_REQ,
    output TICK_IN,
    output TIME_IN,
    input  TX_READY,
    input  FCT_ACK
  );

  modport slave (
    input  TX_WRITE,
    input  TX_DATA,
    input  FCT_REQ,
    input  TICK_IN,
    input  TIME_IN,
    output TX_READY,
    output FCT_ACK
  );
endinterface

// File: rtl/spw_tx_encoder.sv
// SpaceWire D/S transmitter: selects time-code, FCT, N-char or NULL and shifts it out
// one bit per CLK_EN. Optional N-char counter output when SPWTCR_TX_CHAR_COUNT_EN is defined.
module spw_tx_encoder #(
  parameter logic [7:0] EOP_CODE = 8'h00,
  parameter logic [7:0] EEP_CODE = 8'h01
) (
  input  logic             CLOCK,
  input  logic             RESETn,
  input  logic             CLK_EN,
  input  logic             TX_EN,
  input  logic             SEND_FCT_EN,
  input  logic             SEND_DATA_EN,
  spw_tx_encoder_if.slave  host,
  output logic             DOUT,
  output logic             SOUT
`ifdef SPWTCR_TX_CHAR_COUNT_EN
  ,
  output logic [15:0]      TX_NCHAR_CNT
`endif
);

  // Control payload codes; bit [0] is the first payload bit on the wire.
  localparam logic [1:0] CODE_FCT = 2'b00;
  localparam logic [1:0] CODE_EOP = 2'b10;
  localparam logic [1:0] CODE_EEP = 2'b01;
  localparam logic [1:0] CODE_ESC = 2'b11;

  function automatic logic odd_parity(input logic acc, input logic flag);
    return 1'b1 ^ acc ^ flag;
  endfunction

  // Bit [0] of the returned vector is transmitted first.
  function automatic logic [3:0] ctrl_char(input logic acc, input logic [1:0] code);
    return {code[1], code[0], 1'b1, odd_parity(acc, 1'b1)};
  endfunction

  function automatic logic [9:0] data_char(input logic acc, input logic [7:0] data);
    return {data, 1'b0, odd_parity(acc, 1'b0)};
  endfunction

  logic [13:0] seq_r;
  logic [3:0]  bit_cnt_r;
  logic        acc_r;
  logic        started_r;
  logic        dout_r;
  logic        sout_r;
  logic        ready_r;
  logic        fct_ack_r;
  logic        hold_full_r;
  logic [8:0]  hold_data_r;
  logic        tick_pend_r;
  logic [7:0]  tick_time_r;

  logic [13:0] sel_seq_s;
  logic [3:0]  sel_len_s;
  logic        sel_acc_s;
  logic        sel_tick_s;
  logic        sel_fct_s;
  logic        sel_hold_s;
  logic [1:0]  ctrl_code_s;
  logic        select_s;
  logic        accept_s;
  logic        bit_s;
  logic        sout_next_s;
  logic        hold_full_next_s;

  // Priority selection of the next character (or atomic pair) and its resulting parity state.
  always_comb begin
    sel_seq_s   = 14'h0000;
    sel_len_s   = 4'd0;
    sel_acc_s   = 1'b0;
    sel_tick_s  = 1'b0;
    sel_fct_s   = 1'b0;
    sel_hold_s  = 1'b0;
    ctrl_code_s = CODE_EEP;
    if (started_r && tick_pend_r && SEND_DATA_EN) begin
      // ESC payload XORs to 0, so the following data character sees acc=0.
      sel_seq_s  = {data_char(1'b0, tick_time_r), ctrl_char(acc_r, CODE_ESC)};
      sel_len_s  = 4'd14;
      sel_acc_s  = ^tick_time_r;
      sel_tick_s = 1'b1;
    end else if (started_r && host.FCT_REQ && (SEND_FCT_EN || SEND_DATA_EN)) begin
      sel_seq_s  = {10'h000, ctrl_char(acc_r, CODE_FCT)};
      sel_len_s  = 4'd4;
      sel_acc_s  = 1'b0;
      sel_fct_s  = 1'b1;
    end else if (started_r && hold_full_r && SEND_DATA_EN) begin
      sel_hold_s = 1'b1;
      if (hold_data_r[8]) begin
        if (hold_data_r[7:0] == EOP_CODE) begin
          ctrl_code_s = CODE_EOP;
        end else begin
          ctrl_code_s = CODE_EEP;
        end
        sel_seq_s = {10'h000, ctrl_char(acc_r, ctrl_code_s)};
        sel_len_s = 4'd4;
        sel_acc_s = ctrl_code_s[0] ^ ctrl_code_s[1];
      end else begin
        sel_seq_s = {4'h0, data_char(acc_r, hold_data_r[7:0])};
        sel_len_s = 4'd10;
        sel_acc_s = ^hold_data_r[7:0];
      end
    end else begin
      sel_seq_s = {6'h00, ctrl_char(1'b0, CODE_FCT), ctrl_char(acc_r, CODE_ESC)};
      sel_len_s = 4'd8;
      sel_acc_s = 1'b0;
    end
  end

  // Next emitted bit, its strobe, and holding-register occupancy after this edge.
  always_comb begin
    select_s         = CLK_EN && (bit_cnt_r == 4'd0);
    accept_s         = host.TX_WRITE && ready_r;
    bit_s            = 1'b0;
    sout_next_s      = sout_r;
    hold_full_next_s = hold_full_r;
    if (select_s) begin
      bit_s = sel_seq_s[0];
    end else begin
      bit_s = seq_r[0];
    end
    if (bit_s == dout_r) begin
      sout_next_s = ~sout_r;
    end else begin
      sout_next_s = sout_r;
    end
    if (accept_s) begin
      hold_full_next_s = 1'b1;
    end else if (select_s && sel_hold_s) begin
      hold_full_next_s = 1'b0;
    end else begin
      hold_full_next_s = hold_full_r;
    end
  end

  // Serialiser, holding register, pending tick and handshake outputs.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      seq_r       <= 14'h0000;
      bit_cnt_r   <= 4'd0;
      acc_r       <= 1'b0;
      started_r   <= 1'b0;
      dout_r      <= 1'b0;
      sout_r      <= 1'b0;
      ready_r     <= 1'b0;
      fct_ack_r   <= 1'b0;
      hold_full_r <= 1'b0;
      hold_data_r <= 9'h000;
      tick_pend_r <= 1'b0;
      tick_time_r <= 8'h00;
    end else if (!TX_EN) begin
      seq_r       <= 14'h0000;
      bit_cnt_r   <= 4'd0;
      acc_r       <= 1'b0;
      started_r   <= 1'b0;
      dout_r      <= 1'b0;
      sout_r      <= 1'b0;
      ready_r     <= 1'b0;
      fct_ack_r   <= 1'b0;
      hold_full_r <= 1'b0;
      hold_data_r <= 9'h000;
      tick_pend_r <= 1'b0;
      tick_time_r <= 8'h00;
    end else begin
      fct_ack_r <= 1'b0;
      if (CLK_EN) begin
        dout_r <= bit_s;
        sout_r <= sout_next_s;
        if (select_s) begin
          seq_r     <= {1'b0, sel_seq_s[13:1]};
          bit_cnt_r <= sel_len_s - 4'd1;
          acc_r     <= sel_acc_s;
          started_r <= 1'b1;
          fct_ack_r <= sel_fct_s;
        end else begin
          seq_r     <= {1'b0, seq_r[13:1]};
          bit_cnt_r <= bit_cnt_r - 4'd1;
        end
      end
      hold_full_r <= hold_full_next_s;
      ready_r     <= ~hold_full_next_s;
      if (accept_s) begin
        hold_data_r <= host.TX_DATA;
      end
      // A tick arriving on the consuming edge stays pending.
      if (host.TICK_IN) begin
        tick_pend_r <= 1'b1;
        tick_time_r <= host.TIME_IN;
      end else if (select_s && sel_tick_s) begin
        tick_pend_r <= 1'b0;
      end
    end
  end

`ifdef SPWTCR_TX_CHAR_COUNT_EN
  logic [15:0] nchar_cnt_r;

  // Count of N-chars selected since the transmitter was last enabled.
  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      nchar_cnt_r <= 16'h0000;
    end else if (!TX_EN) begin
      nchar_cnt_r <= 16'h0000;
    end else if (select_s && sel_hold_s) begin
      nchar_cnt_r <= nchar_cnt_r + 16'h0001;
    end
  end

  assign TX_NCHAR_CNT = nchar_cnt_r;
`endif

  assign DOUT          = dout_r;
  assign SOUT          = sout_r;
  assign host.TX_READY = ready_r;
  assign host.FCT_ACK  = fct_ack_r;

endmodule

// File: tb/tb_spw_tx_encoder.sv
// Self-checking bench for spw_tx_encoder: directed steps plus random traffic
// compared against a character-level reference model of the D/S line.
module tb_spw_tx_encoder;
  logic CLOCK = 1'b0;
  logic RESETn = 1'b0;
  logic CLK_EN = 1'b0;
  logic TX_EN = 1'b0;
  logic SEND_FCT_EN = 1'b0;
  logic SEND_DATA_EN = 1'b0;
  logic DOUT;
  logic SOUT;
`ifdef SPWTCR_TX_CHAR_COUNT_EN
  logic [15:0] TX_NCHAR_CNT;
`endif

  spw_tx_encoder_if hif();

  spw_tx_encoder dut (
    .CLOCK(CLOCK),
    .RESETn(RESETn),
    .CLK_EN(CLK_EN),
    .TX_EN(TX_EN),
    .SEND_FCT_EN(SEND_FCT_EN),
    .SEND_DATA_EN(SEND_DATA_EN),
    .host(hif),
    .DOUT(DOUT),
    .SOUT(SOUT)
`ifdef SPWTCR_TX_CHAR_COUNT_EN
    ,
    .TX_NCHAR_CNT(TX_NCHAR_CNT)
`endif
  );

  initial forever #5 CLOCK = ~CLOCK;

  localparam int K_NULL = 0;
  localparam int K_FCT  = 1;
  localparam int K_DATA = 2;
  localparam int K_TC   = 3;

  int checks = 0;
  int failures = 0;
  bit dq[$];
  bit sq[$];

  // Reference model state: pending line bits and the host-visible registers.
  bit        m_q[$];
  bit        m_acc, m_d, m_s, m_ready, m_ack, m_full, m_pend, m_started, m_acc_wr;
  bit [8:0]  m_hdata;
  bit [7:0]  m_time;
  bit [15:0] m_cnt;
  int        m_kind;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Append one character: parity, flag, n payload bits (pl[0] first).
  task automatic m_push_char(input bit flag, input int n, input bit [7:0] pl);
    bit x;
    x = 1'b0;
    m_q.push_back(1'b1 ^ m_acc ^ flag);
    m_q.push_back(flag);
    for (int i = 0; i < n; i++) begin
      m_q.push_back(pl[i]);
      x = x ^ pl[i];
    end
    m_acc = x;
  endtask

  task automatic m_null();
    m_push_char(1'b1, 2, 8'b11);
    m_push_char(1'b1, 2, 8'b00);
    m_kind = K_NULL;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic m_step();
    bit b;
    bit take_tick;
    take_tick = 1'b0;
    m_acc_wr  = hif.TX_WRITE && m_ready;
    m_ack     = 1'b0;
    if (!TX_EN) begin
      m_q.delete();
      m_acc = 1'b0; m_d = 1'b0; m_s = 1'b0; m_ready = 1'b0;
      m_full = 1'b0; m_pend = 1'b0; m_started = 1'b0; m_acc_wr = 1'b0;
      m_cnt = 16'h0000;
      return;
    end
    if (CLK_EN) begin
      if (m_q.size() == 0) begin
        if (!m_started) begin
          m_null();
        end else if (m_pend && SEND_DATA_EN) begin
          m_push_char(1'b1, 2, 8'b11);
          m_push_char(1'b0, 8, m_time);
          take_tick = 1'b1;
          m_kind = K_TC;
        end else if (hif.FCT_REQ && (SEND_FCT_EN || SEND_DATA_EN)) begin
          m_push_char(1'b1, 2, 8'b00);
          m_ack = 1'b1;
          m_kind = K_FCT;
        end else if (m_full && SEND_DATA_EN) begin
          if (m_hdata[8] && m_hdata[7:0] == 8'h00) m_push_char(1'b1, 2, 8'b10);
          else if (m_hdata[8]) m_push_char(1'b1, 2, 8'b01);
          else m_push_char(1'b0, 8, m_hdata[7:0]);
          m_full = 1'b0;
          m_cnt = m_cnt + 16'h0001;
          m_kind = K_DATA;
        end else begin
          m_null();
        end
        m_started = 1'b1;
      end
      b = m_q.pop_front();
      if (b == m_d) m_s = ~m_s;
      m_d = b;
    end
    if (m_acc_wr) begin
      m_full = 1'b1;
      m_hdata = hif.TX_DATA;
    end
    if (hif.TICK_IN) begin
      m_pend = 1'b1;
      m_time = hif.TIME_IN;
    end else if (take_tick) begin
      m_pend = 1'b0;
    end
    m_ready = !m_full;
  endtask

  // One clock: model, edge, compare, then host-side housekeeping.
  task automatic step();
    m_step();
    @(posedge CLOCK);
    #1;
    chk("dout", DOUT, m_d);
    chk("sout", SOUT, m_s);
    chk("tx_ready", hif.TX_READY, m_ready);
    chk("fct_ack", hif.FCT_ACK, m_ack);
`ifdef SPWTCR_TX_CHAR_COUNT_EN
    chk("nchar_cnt", TX_NCHAR_CNT, m_cnt);
`endif
    dq.push_back(DOUT);
    sq.push_back(SOUT);
    if (m_acc_wr) hif.TX_WRITE = 1'b0;
    if (m_ack) hif.FCT_REQ = 1'b0;
    hif.TICK_IN = 1'b0;
  endtask

  task automatic rand_host();
    int r;
    if (!hif.TX_WRITE && $urandom_range(3) == 0) begin
      r = $urandom_range(9);
      hif.TX_WRITE = 1'b1;
      if (r == 0) hif.TX_DATA = 9'h100;
      else if (r == 1) hif.TX_DATA = 9'h101;
      else if (r == 2) hif.TX_DATA = {1'b1, 8'($urandom)};
      else hif.TX_DATA = {1'b0, 8'($urandom)};
    end
    if (!hif.FCT_REQ && $urandom_range(15) == 0) hif.FCT_REQ = 1'b1;
    hif.TICK_IN = ($urandom_range(30) == 0);
    hif.TIME_IN = 8'($urandom);
  endtask

  initial begin
    int base, acks, changes, found;
    bit a, b, pd, ps, ce;
    bit exp_null_d[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit exp_null_s[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit exp_t4[28] = '{1'b0, 1'b1, 1'b1, 1'b1,
                       1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                       1'b1, 1'b1, 1'b0, 1'b0,
                       1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit exp_eop[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    hif.TX_WRITE = 1'b0; hif.TX_DATA = 9'h000; hif.FCT_REQ = 1'b0;
    hif.TICK_IN = 1'b0; hif.TIME_IN = 8'h00;
    m_q.delete(); m_acc = 0; m_d = 0; m_s = 0; m_ready = 0; m_ack = 0;
    m_full = 0; m_pend = 0; m_started = 0; m_acc_wr = 0; m_cnt = 16'h0000; m_kind = K_NULL;

    // Reset values
    #12;
    chk("rst_dout", DOUT, 1'b0);
    chk("rst_sout", SOUT, 1'b0);
    chk("rst_ready", hif.TX_READY, 1'b0);
    chk("rst_ack", hif.FCT_ACK, 1'b0);
    RESETn = 1'b1;

    // NULL stream with only TX_EN
    TX_EN = 1'b1; CLK_EN = 1'b1;
    repeat (16) step();
    for (int i = 0; i < 16; i++) chk("t1_null_d", dq[i], exp_null_d[i % 8]);
    for (int i = 0; i < 8; i++) chk("t1_null_s", sq[i], exp_null_s[i]);
    chk("t1_first_ds", dq[0] ^ sq[0], 1'b1);
    for (int i = 1; i < 16; i++) begin
      a = dq[i] ^ sq[i];
      b = ~(dq[i-1] ^ sq[i-1]);
      chk("t1_ds_alt", a, b);
    end
    chk("t1_ready", hif.TX_READY, 1'b1);

    // Data 0x55 then EOP
    SEND_DATA_EN = 1'b1;
    base = dq.size();
    hif.TX_WRITE = 1'b1; hif.TX_DATA = 9'h055;
    step();
    chk("t2_ready_low", hif.TX_READY, 1'b0);
    repeat (8) step();
    chk("t2_ready_sel", hif.TX_READY, 1'b1);
    hif.TX_WRITE = 1'b1; hif.TX_DATA = 9'h100;
    repeat (13) step();
    for (int i = 0; i < 10; i++) chk("t2_data55", dq[base + 8 + i], (i % 2 == 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < 4; i++) chk("t2_eop", dq[base + 18 + i], exp_eop[i]);

    // FCT ahead of pending data
    SEND_FCT_EN = 1'b1;
    base = dq.size();
    acks = 0;
    hif.TX_WRITE = 1'b1; hif.TX_DATA = {1'b0, 8'($urandom)};
    hif.FCT_REQ = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (hif.FCT_ACK === 1'b1) acks++;
    end
    chk("t3_ack_count", acks, 1);
    chk("t3_fct_p", dq[base], 1'b1);
    chk("t3_fct_f", dq[base + 1], 1'b1);
    chk("t3_fct_b2", dq[base + 2], 1'b0);
    chk("t3_fct_b3", dq[base + 3], 1'b0);
    chk("t3_data_p", dq[base + 4], 1'b1);
    chk("t3_data_f", dq[base + 5], 1'b0);

    // Time-code wins over FCT and data; second tick overwrites
    base = dq.size();
    step();
    hif.TX_WRITE = 1'b1; hif.TX_DATA = 9'h0A5;
    hif.FCT_REQ = 1'b1;
    hif.TICK_IN = 1'b1; hif.TIME_IN = 8'h3C;
    repeat (2) step();
    hif.TICK_IN = 1'b1; hif.TIME_IN = 8'h07;
    repeat (33) step();
    for (int i = 0; i < 28; i++) chk("t4_order", dq[base + 8 + i], exp_t4[i]);

    // TX_EN dropped at bit 5 of a data character
    hif.TX_WRITE = 1'b1; hif.TX_DATA = 9'h0C3;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (m_kind == K_DATA && m_q.size() == 5) found = 1;
    end
    chk("t5_reach_bit5", found, 1);
    TX_EN = 1'b0;
    step();
    chk("t5_off_dout", DOUT, 1'b0);
    chk("t5_off_sout", SOUT, 1'b0);
    chk("t5_off_ready", hif.TX_READY, 1'b0);
    hif.FCT_REQ = 1'b1;
    repeat (3) step();
    TX_EN = 1'b1;
    base = dq.size();
    repeat (4) step();
    for (int i = 0; i < 4; i++) chk("t5_restart_esc", dq[base + i], exp_null_d[i]);

    // Slow bit rate: outputs move only on CLK_EN edges
    changes = 0;
    for (int i = 0; i < 400; i++) begin
      CLK_EN = (i % 20 == 0);
      rand_host();
      pd = DOUT; ps = SOUT; ce = CLK_EN;
      step();
      if (!ce && (DOUT !== pd || SOUT !== ps)) changes++;
    end
    chk("t6_hold_between", changes, 0);

    // Random traffic with gating and enable changes
    for (int i = 0; i < 1500; i++) begin
      CLK_EN = ($urandom_range(1) == 0);
      if ($urandom_range(49) == 0) SEND_DATA_EN = ~SEND_DATA_EN;
      if ($urandom_range(49) == 0) SEND_FCT_EN = ~SEND_FCT_EN;
      if (TX_EN && $urandom_range(199) == 0) TX_EN = 1'b0;
      else if (!TX_EN && $urandom_range(3) == 0) TX_EN = 1'b1;
      rand_host();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
